// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared FSM encoding and default parameters for mux_scan_n
package mux_scan_pkg;

    localparam int N_CH_DEF    = 10;
    localparam int W_DEF       = 8;
    localparam int DWELL_W_DEF = 8;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DWELL = 2'd1;
    localparam state_t ST_EMIT  = 2'd2;

endpackage

// File: rtl/mux_sel_n.sv
// rtl/mux_sel_n.sv - combinational N_CH:1 W-bit selector, zero for out-of-range select
module mux_sel_n #(
    parameter int N_CH = 10,
    parameter int W    = 8,
    parameter int SL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] in,
    input  logic [SL_W-1:0]   sel,
    output logic [W-1:0]      data
);

    always_comb begin
        data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SL_W'(k)) begin
                data = in[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - N-channel registered mux with direct/scan modes and valid/ready output
// Optional channel mask for scan sweeps: define MUX_SCAN_MASK_EN.
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter  int N_CH    = N_CH_DEF,
    parameter  int W       = W_DEF,
    parameter  int DWELL_W = DWELL_W_DEF,
    localparam int SL_W    = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in,
    input  logic [SL_W-1:0]   sl,
    input  logic              mode,
    input  logic              start,
    input  logic [DWELL_W-1:0] dwell,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]   ch_mask,
`endif
    output logic [W-1:0]      out,
    output logic [SL_W-1:0]   out_ch,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              busy,
    output logic              err
);

    state_t              state;
    logic [SL_W-1:0]     ptr;
    logic [SL_W-1:0]     sel;
    logic [SL_W-1:0]     nxt_ptr;
    logic [SL_W-1:0]     first_ch;
    logic                has_nxt;
    logic                any_en;
    logic [DWELL_W-1:0]  cnt;
    logic [DWELL_W-1:0]  dwell_lat;
    logic [N_CH-1:0]     scan_mask;
    logic [N_CH-1:0]     start_mask;
    logic [W-1:0]        sel_data;
    logic                free;
    logic                start_scan;

`ifdef MUX_SCAN_MASK_EN
    logic [N_CH-1:0] mask_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_lat <= '0;
        end else if (start_scan) begin
            mask_lat <= ch_mask;
        end
    end

    assign scan_mask  = mask_lat;
    assign start_mask = ch_mask;
`else
    assign scan_mask  = '1;
    assign start_mask = '1;
`endif

    assign free       = !out_vld || out_rdy;
    assign busy       = (state != ST_IDLE);
    assign start_scan = start && mode && (state == ST_IDLE);
    assign sel        = (state == ST_EMIT) ? ptr : sl;

    // Descending walk leaves the lowest qualifying channel as the final assignment.
    always_comb begin
        nxt_ptr  = '0;
        has_nxt  = 1'b0;
        first_ch = '0;
        any_en   = |start_mask;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (scan_mask[i] && (SL_W'(i) > ptr)) begin
                nxt_ptr = SL_W'(i);
                has_nxt = 1'b1;
            end
            if (start_mask[i]) begin
                first_ch = SL_W'(i);
            end
        end
    end

    mux_sel_n #(
        .N_CH (N_CH),
        .W    (W),
        .SL_W (SL_W)
    ) u_sel (
        .in   (in),
        .sel  (sel),
        .data (sel_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            dwell_lat <= '0;
            out       <= '0;
            out_ch    <= '0;
            out_vld   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start_scan) begin
                        if (any_en) begin
                            state     <= ST_DWELL;
                            ptr       <= first_ch;
                            cnt       <= dwell;
                            dwell_lat <= dwell;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (!mode && !start && free) begin
                        out     <= sel_data;
                        out_ch  <= sl;
                        out_vld <= 1'b1;
                        if ({1'b0, sl} >= (SL_W+1)'(N_CH)) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_DWELL: begin
                    if (cnt == '0) begin
                        state <= ST_EMIT;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (free) begin
                        out     <= sel_data;
                        out_ch  <= ptr;
                        out_vld <= 1'b1;
                        if (has_nxt) begin
                            ptr   <= nxt_ptr;
                            cnt   <= dwell_lat;
                            state <= ST_DWELL;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
